// File: rtl/stream_arb_mux_n.sv
// N-to-1 valid/ready stream mux with round-robin or fixed-priority arbitration and optional packet locking.
// Latency: one cycle from input transfer to out_valid; sustains one beat per cycle while out_ready is high.
// Backpressure: a held output beat (out_valid && !out_ready) drops every in_ready until the consumer takes it.
module stream_arb_mux_n #(
   parameter int WIDTH    = 8,
   parameter int N        = 4,
   parameter bit LOCK_PKT = 1'b1,
   parameter int SEL_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rr_en,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   input  logic [N-1:0]       in_last,
   output logic [N-1:0]       in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   output logic               out_last,
   output logic               out_valid,
   input  logic               out_ready
);

   logic [SEL_W-1:0] ptr;
   logic             lock;
   logic [SEL_W-1:0] lock_ch;
   logic [SEL_W-1:0] grant;
   logic             gnt_vld;
   logic             load_en;
   logic             xfer;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;

   assign load_en = !out_valid || out_ready;
   assign xfer    = load_en && gnt_vld;

   // Pick the granted channel: locked channel first, else rotate from ptr, else lowest index.
   // The rotating search runs the wrapped range (below ptr) first and the range from ptr
   // second, so any hit at or above ptr overrides a wrapped hit; descending loops leave the
   // lowest index of each range as the winner.
   always_comb begin
      grant   = '0;
      gnt_vld = 1'b0;
      if (lock) begin
         grant   = lock_ch;
         gnt_vld = in_valid[lock_ch];
      end else if (rr_en) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (i < int'(ptr))) begin
               grant   = SEL_W'(i);
               gnt_vld = 1'b1;
            end
         end
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i] && (i >= int'(ptr))) begin
               grant   = SEL_W'(i);
               gnt_vld = 1'b1;
            end
         end
      end else begin
         for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
               grant   = SEL_W'(i);
               gnt_vld = 1'b1;
            end
         end
      end
   end

   // Route the granted channel's payload and last flag, and raise only its ready.
   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SEL_W'(i)) begin
            sel_data    = in_data[i*WIDTH +: WIDTH];
            sel_last    = in_last[i];
            in_ready[i] = load_en && gnt_vld;
         end
      end
   end

   // Output register: load on transfer, drain when consumed with nothing new, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         out_last  <= 1'b0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= sel_data;
         out_sel   <= grant;
         out_last  <= sel_last;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Arbitration state: packet lock and the round-robin pointer, which advances only at packet end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock    <= 1'b0;
         lock_ch <= '0;
         ptr     <= '0;
      end else if (xfer) begin
         if (LOCK_PKT) begin
            if (sel_last) begin
               lock <= 1'b0;
            end else if (!lock) begin
               lock    <= 1'b1;
               lock_ch <= grant;
            end
         end
         if (sel_last || !LOCK_PKT) begin
            ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stream_arb_mux_n.sv
module tb_stream_arb_mux_n;

   logic        clk;
   logic        rst_n;
   logic        rr_en;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_last;
   logic        out_valid;
   logic        out_ready;

   logic        s_rr;
   logic [31:0] s_data;
   logic [0:0]  s_valid;
   logic [0:0]  s_last;
   logic [0:0]  s_ready;
   logic [31:0] s_out_data;
   logic [0:0]  s_out_sel;
   logic        s_out_last;
   logic        s_out_valid;
   logic        s_out_ready;

   int tests  = 0;
   int failed = 0;

   logic [7:0] pay [4];
   logic [31:0] sq [$];

   stream_arb_mux_n #(.WIDTH(8), .N(4), .LOCK_PKT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .rr_en(rr_en),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   stream_arb_mux_n #(.WIDTH(32), .N(1), .LOCK_PKT(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rr_en(s_rr),
      .in_data(s_data), .in_valid(s_valid), .in_last(s_last), .in_ready(s_ready),
      .out_data(s_out_data), .out_sel(s_out_sel), .out_last(s_out_last),
      .out_valid(s_out_valid), .out_ready(s_out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rr;
      logic [3:0] vld;
      logic [3:0] last;
      logic       ord;
      logic [3:0] erdy;
      logic       eovld;
      logic [1:0] esel;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = '0; in_last = '0; out_ready = 1'b1; rr_en = 1'b1;
      s_valid = '0; s_last = '0; s_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Drive one beat pattern, check in_ready before the edge and the output register after it.
   task automatic apply(input string nm, input logic rr, input logic [3:0] vld, input logic [3:0] last,
                        input logic ord, input logic [3:0] erdy, input logic eovld, input logic [1:0] esel);
      in_data   = {pay[3], pay[2], pay[1], pay[0]};
      rr_en     = rr;
      in_valid  = vld;
      in_last   = last;
      out_ready = ord;
      @(negedge clk);
      chk({nm, " in_ready"}, 32'(in_ready), 32'(erdy));
      @(posedge clk);
      #1;
      chk({nm, " out_valid"}, 32'(out_valid), 32'(eovld));
      chk({nm, " out_sel"}, 32'(out_sel), 32'(esel));
      chk({nm, " out_data"}, 32'(out_data), 32'(pay[esel]));
   endtask

   // One cycle of the single-channel instance against an in-order scoreboard.
   task automatic n1_cycle(input logic v, input logic o);
      s_valid     = v;
      s_data      = $urandom;
      s_last      = 1'($urandom_range(0, 1));
      s_out_ready = o;
      @(negedge clk);
      if (s_out_valid && s_out_ready) begin
         if (sq.size() == 0) begin
            chk("n1 unexpected beat", 32'(s_out_valid), 32'd0);
         end else begin
            chk("n1 out_data", s_out_data, sq.pop_front());
            chk("n1 out_sel", 32'(s_out_sel), 32'd0);
         end
      end
      if (s_valid[0] && s_ready[0]) sq.push_back(s_data);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         m_ptr, m_lch, m_sel, g;
      logic       m_lock, m_vld, m_last, load;
      logic [7:0] m_dat;
      logic [3:0] erdy;

      pay[0] = 8'h11; pay[1] = 8'hA5; pay[2] = 8'h33; pay[3] = 8'h44;
      in_data = '0; s_data = '0; s_rr = 1'b0;

      //           rr   vld      last     ord  erdy     eovld esel
      vecs[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[2]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
      vecs[3]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[4]  = '{1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
      vecs[5]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[6]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[7]  = '{1'b0, 4'b1010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[8]  = '{1'b0, 4'b1000, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
      vecs[9]  = '{1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd3};
      vecs[10] = '{1'b1, 4'b0110, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
      vecs[11] = '{1'b1, 4'b0110, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};

      do_reset();
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data", 32'(out_data), 32'd0);
      chk("reset out_sel", 32'(out_sel), 32'd0);
      chk("reset out_last", 32'(out_last), 32'd0);
      chk("reset n1 out_valid", 32'(s_out_valid), 32'd0);

      for (int i = 0; i < 12; i++) begin
         apply($sformatf("vec%0d", i), vecs[i].rr, vecs[i].vld, vecs[i].last, vecs[i].ord,
               vecs[i].erdy, vecs[i].eovld, vecs[i].esel);
      end

      // Packet lock on channel 2 with an input gap while channel 0 keeps requesting.
      do_reset();
      apply("lock a", 1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0);
      apply("lock b", 1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2);
      apply("lock gap1", 1'b1, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd2);
      apply("lock gap2", 1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd2);
      apply("lock c", 1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0100, 1'b1, 2'd2);
      apply("lock d", 1'b1, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2);
      apply("lock after", 1'b1, 4'b1001, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3);

      // Backpressure: a channel-1 beat held for five cycles, then released.
      do_reset();
      apply("bp load", 1'b0, 4'b0010, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1);
      for (int i = 0; i < 5; i++) begin
         apply($sformatf("bp hold%0d", i), 1'b0, 4'b0011, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1);
      end
      apply("bp release", 1'b0, 4'b0011, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);
      apply("bp drain", 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0);

      // Asynchronous reset in the middle of a locked packet.
      do_reset();
      apply("rst lock", 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2);
      in_valid = 4'b0000;
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", 32'(out_valid), 32'd0);
      chk("async rst out_data", 32'(out_data), 32'd0);
      chk("async rst out_sel", 32'(out_sel), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply("rst restart", 1'b1, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0);

      // Random traffic against a queue-free behavioural model of the arbiter.
      do_reset();
      m_ptr = 0; m_lock = 1'b0; m_lch = 0; m_vld = 1'b0; m_dat = '0; m_sel = 0; m_last = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 15) == 0) rr_en = ~rr_en;
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         in_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         g = -1;
         if (m_lock) begin
            if (in_valid[m_lch]) g = m_lch;
         end else if (rr_en) begin
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
            end
         end else begin
            for (int c = 0; c < 4; c++) begin
               if (g < 0 && in_valid[c]) g = c;
            end
         end
         load = !m_vld || out_ready;
         erdy = (load && g >= 0) ? 4'(1 << g) : 4'd0;
         chk("rand in_ready", 32'(in_ready), 32'(erdy));
         if (load && g >= 0) begin
            m_vld  = 1'b1;
            m_dat  = in_data[g*8 +: 8];
            m_sel  = g;
            m_last = in_last[g];
            if (in_last[g]) begin
               m_lock = 1'b0;
               m_ptr  = (g + 1) % 4;
            end else if (!m_lock) begin
               m_lock = 1'b1;
               m_lch  = g;
            end
         end else if (m_vld && out_ready) begin
            m_vld = 1'b0;
         end
         @(posedge clk);
         #1;
         chk("rand out_valid", 32'(out_valid), 32'(m_vld));
         chk("rand out_data", 32'(out_data), 32'(m_dat));
         chk("rand out_sel", 32'(out_sel), 32'(m_sel));
         chk("rand out_last", 32'(out_last), 32'(m_last));
      end

      // Single-channel instance: output stream must equal input stream.
      in_valid = '0;
      sq.delete();
      for (int cyc = 0; cyc < 1000; cyc++) begin
         n1_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      for (int cyc = 0; cyc < 4; cyc++) n1_cycle(1'b0, 1'b1);
      chk("n1 beats left over", 32'(sq.size()), 32'd0);
      chk("n1 drained out_valid", 32'(s_out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
